// File: rtl/fft4_serializer.sv
`default_nettype none
// fft4_serializer: two-frame ping-pong buffer that streams each fft4 frame as 4 complex beats.
// Macro FFT4_SER_SCALE_EN: scale components by 1/4 (round half up, saturate) at capture.
module fft4_serializer #(
   parameter int DATA_WIDTH = 8,
`ifdef FFT4_SER_SCALE_EN
   localparam int OUT_W = DATA_WIDTH,
`else
   localparam int OUT_W = DATA_WIDTH + 2,
`endif
   localparam int IN_W = DATA_WIDTH + 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [IN_W-1:0]  in0_real,
   input  logic signed [IN_W-1:0]  in0_imag,
   input  logic signed [IN_W-1:0]  in1_real,
   input  logic signed [IN_W-1:0]  in1_imag,
   input  logic signed [IN_W-1:0]  in2_real,
   input  logic signed [IN_W-1:0]  in2_imag,
   input  logic signed [IN_W-1:0]  in3_real,
   input  logic signed [IN_W-1:0]  in3_imag,
   output logic signed [OUT_W-1:0] out_real,
   output logic signed [OUT_W-1:0] out_imag,
   output logic [1:0]              out_idx,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    overflow,
   output logic                    busy
);

   function automatic logic signed [OUT_W-1:0] scale(input logic signed [IN_W-1:0] x);
`ifdef FFT4_SER_SCALE_EN
      logic signed [IN_W:0] s;
      logic signed [IN_W:0] sat_hi;
      logic signed [IN_W:0] sat_lo;
      sat_hi = (IN_W+1)'((2 ** (DATA_WIDTH-1)) - 1);
      sat_lo = (IN_W+1)'(-(2 ** (DATA_WIDTH-1)));
      // One guard bit so the +2 rounding offset cannot wrap.
      s = $signed({x[IN_W-1], x}) + (IN_W+1)'(2);
      s = s >>> 2;
      if (s > sat_hi)
         s = sat_hi;
      else if (s < sat_lo)
         s = sat_lo;
      return s[OUT_W-1:0];
`else
      return x;
`endif
   endfunction

   logic signed [IN_W-1:0]  in_re [4];
   logic signed [IN_W-1:0]  in_im [4];
   logic signed [OUT_W-1:0] frame_re [2][4];
   logic signed [OUT_W-1:0] frame_im [2][4];

   logic [1:0] count;
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] beat;
   logic       pop;
   logic       advance;
   logic       accept;

   assign in_re[0] = in0_real;
   assign in_re[1] = in1_real;
   assign in_re[2] = in2_real;
   assign in_re[3] = in3_real;
   assign in_im[0] = in0_imag;
   assign in_im[1] = in1_imag;
   assign in_im[2] = in2_imag;
   assign in_im[3] = in3_imag;

   assign out_valid = (count != 2'd0);
   assign busy      = out_valid;
   assign advance   = out_valid & out_ready;
   assign pop       = advance & (beat == 2'd3);
   // A full buffer still takes a frame when the last beat leaves on the same edge.
   assign accept    = in_valid & ((count != 2'd2) | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         beat     <= 2'd0;
         overflow <= 1'b0;
      end else begin
         if (accept)
            wr_ptr <= ~wr_ptr;
         if (in_valid && !accept)
            overflow <= 1'b1;
         if (advance)
            beat <= beat + 2'd1;
         if (pop)
            rd_ptr <= ~rd_ptr;
         if (accept && !pop)
            count <= count + 2'd1;
         else if (pop && !accept)
            count <= count - 2'd1;
      end
   end

   // Frame storage needs no reset: every slot is written before it becomes readable.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int b = 0; b < 4; b++) begin
            frame_re[wr_ptr][b] <= scale(in_re[b]);
            frame_im[wr_ptr][b] <= scale(in_im[b]);
         end
      end
   end

   always_comb begin
      out_real = '0;
      out_imag = '0;
      out_idx  = 2'd0;
      out_last = 1'b0;
      if (out_valid) begin
         out_real = frame_re[rd_ptr][beat];
         out_imag = frame_im[rd_ptr][beat];
         out_idx  = beat;
         out_last = (beat == 2'd3);
      end
   end

endmodule
`default_nettype wire
